psum_acc: RTL and testbench

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_acc_if.sv | 11 +
 rtl/psum_acc.sv | 98 +++++++++
 tb/tb_psum_acc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/psum_acc_if.sv
// psum_acc_if: psum input stream and accumulated-result output stream for psum_acc
interface psum_acc_if #(parameter int psum_bw = 16);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [psum_bw-1:0] in_psum;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [psum_bw-1:0] out_data;
  modport master (output in_valid, in_psum, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_psum, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/psum_acc.sv
// psum_acc: multi-pass saturating partial-sum accumulator with drain stream; PSUM_ACC_RELU_EN clamps drained values at zero
module psum_acc #(
  parameter int psum_bw = 16,
  parameter int depth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cfg_len,
  input  logic [3:0] cfg_pass,
  psum_acc_if.slave  bus,
  output logic       busy,
  output logic       done
);
  localparam int aw = $clog2(depth);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [aw-1:0] idx_q, idx_d, len_q, len_d;
  logic [3:0] pass_q, pass_d, passes_q, passes_d;
  logic in_ready_q, out_valid_q, busy_q, done_q;
  logic signed [psum_bw-1:0] acc_q [depth];
  logic signed [psum_bw-1:0] rd, sat;
  logic signed [psum_bw:0] sum;
  logic in_fire, out_fire, last_idx;
  assign rd = acc_q[idx_q];
  assign in_fire = bus.in_valid && in_ready_q;
  assign out_fire = bus.out_ready && out_valid_q;
  assign last_idx = idx_q == len_q;
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef PSUM_ACC_RELU_EN
  assign bus.out_data = (out_valid_q && !rd[psum_bw-1]) ? rd : '0;
`else
  assign bus.out_data = out_valid_q ? rd : '0;
`endif
  // one extra bit of headroom, then clamp when the top two bits disagree
  always_comb begin
    sum = (pass_q == 4'd0 ? '0 : {rd[psum_bw-1], rd}) + {bus.in_psum[psum_bw-1], bus.in_psum};
    sat = (sum[psum_bw] != sum[psum_bw-1]) ? {sum[psum_bw], {(psum_bw-1){~sum[psum_bw]}}} : sum[psum_bw-1:0];
  end
  // next-state: walk entries within a pass, passes within a job, then drain
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pass_d = pass_q;
    len_d = len_q;
    passes_d = passes_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACC;
        idx_d = '0;
        pass_d = '0;
        len_d = aw'(cfg_len);
        passes_d = cfg_pass;
      end
      ACC: if (in_fire) begin
        idx_d = last_idx ? '0 : idx_q + 1'b1;
        pass_d = last_idx ? pass_q + 4'd1 : pass_q;
        state_d = (last_idx && pass_q == passes_q) ? DRAIN : ACC;
      end
      DRAIN: if (out_fire) begin
        idx_d = last_idx ? '0 : idx_q + 1'b1;
        state_d = last_idx ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // control state and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      pass_q <= '0;
      len_q <= '0;
      passes_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pass_q <= pass_d;
      len_q <= len_d;
      passes_q <= passes_d;
      in_ready_q <= state_d == ACC;
      out_valid_q <= state_d == DRAIN;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end
  // accumulator storage; first pass overwrites so no clear is needed
  always_ff @(posedge clk) begin
    if (!reset && in_fire) acc_q[idx_q] <= sat;
  end
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: randomized and directed jobs checked against a per-entry saturating sum model
module tb_psum_acc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] cfg_len = '0;
  logic [3:0] cfg_pass = '0;
  logic busy, done;
  int nchk = 0;
  int npass = 0;
  int wq[$];
  int expv[16];
  psum_acc_if bus();
  psum_acc dut (.clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_pass(cfg_pass), .bus(bus.slave), .busy(busy), .done(done));
  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int clamp(int v);
    return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(int len);
    int s[16];
    for (int k = 0; k < wq.size(); k++) begin
      int e = k % (len + 1);
      s[e] = (k <= len) ? clamp(wq[k]) : clamp(s[e] + wq[k]);
    end
    for (int e = 0; e < 16; e++) begin
`ifdef PSUM_ACC_RELU_EN
      expv[e] = s[e] < 0 ? 0 : s[e];
`else
      expv[e] = s[e];
`endif
    end
  endtask

  task automatic rand_words(int n);
    wq.delete();
    repeat (n) wq.push_back($urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100);
  endtask

  task automatic run_job(int len, int passes, int gap, int stall, bit poke);
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    int n = (len + 1) * (passes + 1);
    model(len);
    cfg_len = 4'(len);
    cfg_pass = 4'(passes);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_len = 4'($urandom);
    cfg_pass = 4'($urandom);
    chk("busy_start", busy, 1);
    while (sent < n && cyc < 2000) begin
      chk("in_ready", bus.in_ready, 1);
      chk("out_valid_acc", bus.out_valid, 0);
      bus.in_valid = $urandom_range(0, 99) >= gap;
      bus.in_psum = 16'(wq[sent]);
      bus.out_ready = 1'($urandom);
      tick();
      cyc++;
      if (bus.in_valid) sent++;
    end
    if (cyc >= 2000) chk("acc_timeout", 0, 1);
    bus.in_valid = 1'b0;
    chk("in_ready_after", bus.in_ready, 0);
    cyc = 0;
    while (rcv <= len && cyc < 2000) begin
      chk("out_valid", bus.out_valid, 1);
      chk($sformatf("out_data[%0d]", rcv), int'($signed(bus.out_data)), expv[rcv]);
      bus.out_ready = $urandom_range(0, 99) >= stall;
      start = poke && cyc == 0;
      if (start) begin
        cfg_len = ~4'(len);
        cfg_pass = ~4'(passes);
      end
      tick();
      cyc++;
      start = 1'b0;
      if (bus.out_ready) rcv++;
    end
    if (cyc >= 2000) chk("drain_timeout", 0, 1);
    bus.out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("out_valid_done", bus.out_valid, 0);
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("in_ready_idle", bus.in_ready, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_psum = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", int'($signed(bus.out_data)), 0);
    reset = 1'b0;
    tick();
    wq = '{1, 2, 3, 4};
    run_job(3, 0, 0, 0, 1'b0);
    wq = '{5, -7, 5, -7, 5, -7};
    run_job(1, 2, 0, 0, 1'b0);
    wq = '{16000, 16000, 16000, 16000};
    run_job(0, 3, 0, 0, 1'b0);
    wq = '{-20000, -20000};
    run_job(0, 1, 0, 0, 1'b0);
    rand_words(8);
    run_job(3, 1, 40, 50, 1'b0);
    rand_words(12);
    run_job(5, 1, 30, 40, 1'b1);
    // abandon a job after two of eight words
    cfg_len = 4'd7;
    cfg_pass = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_psum = 16'sd1000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out_data", int'($signed(bus.out_data)), 0);
    tick();
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);
    rand_words(8);
    run_job(7, 0, 20, 20, 1'b0);
    for (int j = 0; j < 20; j++) begin
      int len = $urandom_range(0, 15);
      int passes = $urandom_range(0, 3);
      rand_words((len + 1) * (passes + 1));
      run_job(len, passes, $urandom_range(0, 60), $urandom_range(0, 60), 1'($urandom));
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
